// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
//   Drives one DSP48A1-style multiply-accumulate slice through an N-term dot
//   product sum(A[i]*B[i]). A command (start_i + len_i) clears the slice's P
//   register, streams len_i operand pairs into the slice, waits for the
//   slice pipeline to settle, then captures P and offers it as the result.
//
// Ports
//   clk_i, rst_ni          clock (rising edge) / asynchronous active-low reset
//   start_i, len_i         command strobe and pair count, sampled in IDLE only
//   busy_o                 high whenever the sequencer is not IDLE
//   in_valid_i/in_ready_o  operand pair handshake, in_a_i / in_b_i operands
//   dsp_a_o, dsp_b_o       registered operands to the slice
//   dsp_ce_o               clock enable for every slice pipeline stage
//   dsp_rstp_o             synchronous P-register clear to the slice
//   dsp_p_i                slice accumulator output
//   res_valid_o/res_ready_i result handshake, res_data_o captured dot product
module dsp_mac_sequencer #(
  parameter int AWIDTH   = 18,
  parameter int PWIDTH   = 48,
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [AWIDTH-1:0] in_a_i,
  input  logic [AWIDTH-1:0] in_b_i,
  output logic [AWIDTH-1:0] dsp_a_o,
  output logic [AWIDTH-1:0] dsp_b_o,
  output logic              dsp_ce_o,
  output logic              dsp_rstp_o,
  input  logic [PWIDTH-1:0] dsp_p_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [PWIDTH-1:0] res_data_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  // The last operand pair sits in dsp_a/dsp_b for one cycle before the slice
  // starts its PIPE_LAT-stage walk, so the drain spans PIPE_LAT+1 counted
  // cycles plus the capture cycle. That makes res_valid rise exactly
  // PIPE_LAT+2 cycles after the last accept, regardless of earlier bubbles.
  localparam int             DRAIN_W    = 5;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_LAT + 1);

  state_t              state_q;
  logic [LEN_W-1:0]    beat_q;
  logic [DRAIN_W-1:0]  drain_q;
  logic                in_ready_q;
  logic                dsp_ce_q;
  logic                dsp_rstp_q;
  logic [AWIDTH-1:0]   dsp_a_q;
  logic [AWIDTH-1:0]   dsp_b_q;
  logic                res_valid_q;
  logic [PWIDTH-1:0]   res_data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      drain_q     <= '0;
      in_ready_q  <= 1'b0;
      dsp_ce_q    <= 1'b0;
      dsp_rstp_q  <= 1'b0;
      dsp_a_q     <= '0;
      dsp_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (len_i != '0) begin
              beat_q     <= len_i;
              dsp_rstp_q <= 1'b1;
              dsp_ce_q   <= 1'b1;
              dsp_a_q    <= '0;
              dsp_b_q    <= '0;
              state_q    <= S_CLEAR;
            end else begin
              // Empty dot product: no slice activity, result is zero.
              res_data_q  <= '0;
              res_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end

        S_CLEAR: begin
          dsp_rstp_q <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= S_FEED;
        end

        S_FEED: begin
          if (in_valid_i && in_ready_q) begin
            dsp_a_q <= in_a_i;
            dsp_b_q <= in_b_i;
            beat_q  <= beat_q - 1'b1;
            if (beat_q == LEN_W'(1)) begin
              in_ready_q <= 1'b0;
              drain_q    <= DRAIN_LOAD;
              state_q    <= S_DRAIN;
            end
          end else begin
            // Bubble: a zero product keeps the pipeline moving without
            // disturbing the running sum.
            dsp_a_q <= '0;
            dsp_b_q <= '0;
          end
        end

        S_DRAIN: begin
          dsp_a_q <= '0;
          dsp_b_q <= '0;
          if (drain_q == '0) begin
            res_data_q  <= dsp_p_i;
            res_valid_q <= 1'b1;
            dsp_ce_q    <= 1'b0;
            state_q     <= S_DONE;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end

        S_DONE: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign in_ready_o  = in_ready_q;
  assign dsp_a_o     = dsp_a_q;
  assign dsp_b_o     = dsp_b_q;
  assign dsp_ce_o    = dsp_ce_q;
  assign dsp_rstp_o  = dsp_rstp_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer
//   Directed bench for dsp_mac_sequencer with a behavioural DSP slice model
//   (operand register in the sequencer, 3-deep product pipe, P accumulator).
module tb_dsp_mac_sequencer;

  localparam int AWIDTH   = 18;
  localparam int PWIDTH   = 48;
  localparam int LEN_W    = 8;
  localparam int PIPE_LAT = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [AWIDTH-1:0] in_a;
  logic [AWIDTH-1:0] in_b;
  logic [AWIDTH-1:0] dsp_a;
  logic [AWIDTH-1:0] dsp_b;
  logic              dsp_ce;
  logic              dsp_rstp;
  logic [PWIDTH-1:0] dsp_p;
  logic              res_valid;
  logic              res_ready;
  logic [PWIDTH-1:0] res_data;

  int n_checks = 0;
  int n_errors = 0;
  int rstp_cnt = 0;
  int rdy_cnt  = 0;

  logic signed [AWIDTH-1:0] qa[$];
  logic signed [AWIDTH-1:0] qb[$];

  dsp_mac_sequencer #(
    .AWIDTH  (AWIDTH),
    .PWIDTH  (PWIDTH),
    .LEN_W   (LEN_W),
    .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .len_i      (len),
    .busy_o     (busy),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_a_i     (in_a),
    .in_b_i     (in_b),
    .dsp_a_o    (dsp_a),
    .dsp_b_o    (dsp_b),
    .dsp_ce_o   (dsp_ce),
    .dsp_rstp_o (dsp_rstp),
    .dsp_p_i    (dsp_p),
    .res_valid_o(res_valid),
    .res_ready_i(res_ready),
    .res_data_o (res_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slice model: product enters the pipe on the edge after the operands
  // appear, and is added into P PIPE_LAT edges after they appeared.
  // dsp_rstp clears the M pipe too, as the wrapper ties RSTM to RSTP.
  logic signed [PWIDTH-1:0] mpipe [0:PIPE_LAT-2];
  logic signed [PWIDTH-1:0] p_model;
  logic signed [2*AWIDTH-1:0] prod36;

  assign prod36 = $signed(dsp_a) * $signed(dsp_b);
  assign dsp_p  = p_model;

  initial begin
    p_model = '0;
    for (int i = 0; i < PIPE_LAT-1; i++) mpipe[i] = '0;
  end

  always @(posedge clk) begin
    if (dsp_ce) begin
      if (dsp_rstp) begin
        p_model <= '0;
        for (int i = 0; i < PIPE_LAT-1; i++) mpipe[i] <= '0;
      end else begin
        mpipe[0] <= {{(PWIDTH-2*AWIDTH){prod36[2*AWIDTH-1]}}, prod36};
        for (int i = 1; i < PIPE_LAT-1; i++) mpipe[i] <= mpipe[i-1];
        p_model <= p_model + mpipe[PIPE_LAT-2];
      end
    end
  end

  always @(posedge clk) begin
    if (dsp_rstp) rstp_cnt <= rstp_cnt + 1;
    if (in_ready) rdy_cnt  <= rdy_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a command over qa/qb with `gap` bubble cycles after each accept,
  // then wait for res_valid. Leaves the result pending in DONE.
  task automatic run_dot(input string tag, input int n, input int gap, input logic [47:0] exp_res);
    int idx;
    int bubbles;
    int guard;
    int lat;
    logic acc;
    @(posedge clk); #1;
    start = 1'b1;
    len   = n[LEN_W-1:0];
    @(posedge clk); #1;
    start = 1'b0;
    len   = '0;
    check_val({tag, "_busy"}, 64'(busy), 64'd1);
    check_val({tag, "_rstp"}, 64'(dsp_rstp), 64'd1);
    idx = 0;
    bubbles = 0;
    guard = 0;
    while (idx < n && guard < 4000) begin
      if (bubbles > 0) begin
        in_valid = 1'b0;
        check_val({tag, "_rdy_bubble"}, 64'(in_ready), 64'd1);
      end else begin
        in_valid = 1'b1;
        in_a = qa[idx];
        in_b = qb[idx];
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        bubbles = gap;
      end else if (bubbles > 0) begin
        bubbles--;
      end
      guard++;
    end
    in_valid = 1'b0;
    check_val({tag, "_accepts"}, 64'(idx), 64'(n));
    check_val({tag, "_rdy_drop"}, 64'(in_ready), 64'd0);
    lat = 0;
    while (!res_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check_val({tag, "_lat"}, 64'(lat), 64'(PIPE_LAT + 2));
    check_val({tag, "_res"}, 64'(res_data), 64'(exp_res));
    $display("txn %s len=%0d gap=%0d res=%0h lat=%0d", tag, n, gap, res_data, lat);
  endtask

  task automatic complete(input string tag);
    res_ready = 1'b1;
    @(posedge clk); #1;
    check_val({tag, "_busy_end"}, 64'(busy), 64'd0);
    check_val({tag, "_valid_end"}, 64'(res_valid), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"},   64'(busy),      64'd0);
    check_val({tag, "_rdy"},    64'(in_ready),  64'd0);
    check_val({tag, "_ce"},     64'(dsp_ce),    64'd0);
    check_val({tag, "_rstp"},   64'(dsp_rstp),  64'd0);
    check_val({tag, "_valid"},  64'(res_valid), 64'd0);
    check_val({tag, "_a"},      64'(dsp_a),     64'd0);
    check_val({tag, "_b"},      64'(dsp_b),     64'd0);
    check_val({tag, "_data"},   64'(res_data),  64'd0);
  endtask

  initial begin
    logic [63:0] big;
    logic [47:0] exp_res;
    int r0;
    int i0;
    int acc_n;
    int guard;
    logic acc;

    rst_n = 1'b0;
    start = 1'b0;
    len = '0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    res_ready = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Back-to-back pairs: 6 + 20 - 6 = 20.
    qa = '{18'sd2, 18'sd4, -18'sd1};
    qb = '{18'sd3, 18'sd5, 18'sd6};
    run_dot("b2b", 3, 0, 48'd20);
    complete("b2b");

    // Two bubbles between pairs: 1 + 4 + 9 + 16 = 30.
    qa = '{18'sd1, 18'sd2, 18'sd3, 18'sd4};
    qb = '{18'sd1, 18'sd2, 18'sd3, 18'sd4};
    run_dot("gaps", 4, 2, 48'd30);
    complete("gaps");

    // Zero length: straight to DONE, no clear pulse, no in_ready.
    r0 = rstp_cnt;
    i0 = rdy_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    len = '0;
    @(posedge clk); #1;
    start = 1'b0;
    check_val("len0_valid", 64'(res_valid), 64'd1);
    check_val("len0_data", 64'(res_data), 64'd0);
    check_val("len0_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check_val("len0_busy_end", 64'(busy), 64'd0);
    check_val("len0_rstp_cnt", 64'(rstp_cnt - r0), 64'd0);
    check_val("len0_rdy_cnt", 64'(rdy_cnt - i0), 64'd0);
    $display("txn len0 res=%0h", res_data);

    // Result held in DONE under back-pressure; start pulses ignored.
    res_ready = 1'b0;
    qa = '{18'sd3, 18'sd5};
    qb = '{18'sd4, 18'sd6};
    run_dot("hold", 2, 1, 48'd42);
    for (int c = 0; c < 5; c++) begin
      start = (c == 1 || c == 2);
      len = 8'd7;
      @(posedge clk); #1;
      check_val("hold_valid", 64'(res_valid), 64'd1);
      check_val("hold_data", 64'(res_data), 64'd42);
    end
    start = 1'b0;
    len = '0;
    complete("hold");
    @(posedge clk); #1;
    check_val("hold_no_queue", 64'(busy), 64'd0);

    // Reset mid-FEED after 2 of 5 beats.
    @(posedge clk); #1;
    start = 1'b1;
    len = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    in_a = 18'sd7;
    in_b = 18'sd9;
    acc_n = 0;
    guard = 0;
    while (acc_n < 2 && guard < 20) begin
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) acc_n++;
      guard++;
    end
    check_val("abort_accepts", 64'(acc_n), 64'd2);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("txn abort after %0d beats", acc_n);
    qa = '{18'h20000, 18'sd1};
    qb = '{18'sd131071, 18'sd1};
    exp_res = -48'sd17179738111;
    run_dot("post_abort", 2, 0, exp_res);
    complete("post_abort");

    // Maximum length: 255 * 131071^2 = 255 * 17179607041.
    qa.delete();
    qb.delete();
    for (int k = 0; k < 255; k++) begin
      qa.push_back(18'sd131071);
      qb.push_back(18'sd131071);
    end
    big = 64'd255 * 64'd17179607041;
    exp_res = big[47:0];
    run_dot("maxlen", 255, 0, exp_res);
    complete("maxlen");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
